// File: rtl/csr_counter_bank.sv
// Bank of cycle, instret and NUM_HPM hpmcounter CSRs with mcountinhibit.
// Define CSR_CNT_OVF_EN to add sticky overflow flags at 0x7C0 and a registered ovf_irq.
module csr_counter_bank #(
  parameter int NUM_HPM   = 4,
  parameter int CNT_WIDTH = 64
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [11:0]        raddr,
  output logic [31:0]        rdata,
  output logic               raddr_err,
  input  logic               wen,
  input  logic [11:0]        waddr,
  input  logic [31:0]        wdata,
  input  logic               retire,
  input  logic [NUM_HPM-1:0] hpm_event,
  output logic               ovf_irq
);

  // Counter slot k follows the mcountinhibit bit layout: 0 cycle, 1 time (absent), 2 instret, 3+ hpm.
  localparam int NC = NUM_HPM + 3;
  localparam logic [31:0] IMPL_MASK = ((32'd1 << NC) - 32'd1) & ~32'd2;

  logic [CNT_WIDTH-1:0] cnt_q [NC];
  logic [CNT_WIDTH-1:0] cnt_d [NC];
  logic [31:0]          inh_q, inh_d;
  logic [NC-1:0]        inc_ev, incr, wr_lo, wr_hi;

`ifdef CSR_CNT_OVF_EN
  logic [31:0] ovf_q, ovf_d, ovf_set;
  logic        irq_q, irq_d;
`endif

  always_comb begin
    inc_ev         = '0;
    inc_ev[0]      = 1'b1;
    inc_ev[2]      = retire;
    inc_ev[NC-1:3] = hpm_event;
    incr           = inc_ev & ~inh_q[NC-1:0] & IMPL_MASK[NC-1:0];
  end

  always_comb begin
    wr_lo = '0;
    wr_hi = '0;
    for (int k = 0; k < NC; k++) begin
      wr_lo[k] = wen && IMPL_MASK[k] && (waddr == 12'hC00 + 12'(k));
      wr_hi[k] = wen && IMPL_MASK[k] && (waddr == 12'hC80 + 12'(k));
    end
  end

  // A written counter skips its increment; the rest of the bank keeps counting.
  always_comb begin
    for (int k = 0; k < NC; k++) begin
      cnt_d[k] = cnt_q[k];
      if (!nrst || !IMPL_MASK[k]) begin
        cnt_d[k] = '0;
      end else if (wr_lo[k]) begin
        cnt_d[k] = {cnt_q[k][CNT_WIDTH-1:32], wdata};
      end else if (wr_hi[k]) begin
        cnt_d[k] = {wdata[CNT_WIDTH-33:0], cnt_q[k][31:0]};
      end else if (incr[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    inh_d = inh_q;
    if (wen && (waddr == 12'h320)) begin
      inh_d = wdata & IMPL_MASK;
    end
    if (!nrst) begin
      inh_d = '0;
    end
  end

`ifdef CSR_CNT_OVF_EN
  // Only a counting step out of all-ones flags an overflow; write-induced wraps do not.
  always_comb begin
    ovf_set = '0;
    for (int k = 0; k < NC; k++) begin
      ovf_set[k] = incr[k] && !wr_lo[k] && !wr_hi[k] && (&cnt_q[k]);
    end
    ovf_d = ovf_q;
    if (wen && (waddr == 12'h7C0)) begin
      ovf_d = ovf_q & ~wdata;
    end
    ovf_d = ovf_d | ovf_set;
    irq_d = |ovf_q;
    if (!nrst) begin
      ovf_d = '0;
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    ovf_q <= ovf_d;
    irq_q <= irq_d;
  end

  assign ovf_irq = irq_q;
`else
  assign ovf_irq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      cnt_q[k] <= cnt_d[k];
    end
    inh_q <= inh_d;
  end

  always_comb begin
    rdata     = '0;
    raddr_err = 1'b1;
    for (int k = 0; k < NC; k++) begin
      if (IMPL_MASK[k] && (raddr == 12'hC00 + 12'(k))) begin
        rdata     = cnt_q[k][31:0];
        raddr_err = 1'b0;
      end
      if (IMPL_MASK[k] && (raddr == 12'hC80 + 12'(k))) begin
        rdata                  = '0;
        rdata[CNT_WIDTH-33:0]  = cnt_q[k][CNT_WIDTH-1:32];
        raddr_err              = 1'b0;
      end
    end
    if (raddr == 12'h320) begin
      rdata     = inh_q;
      raddr_err = 1'b0;
    end
`ifdef CSR_CNT_OVF_EN
    if (raddr == 12'h7C0) begin
      rdata     = ovf_q;
      raddr_err = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Bench for csr_counter_bank (NUM_HPM=2, CNT_WIDTH=40) against an arithmetic model of the CSR bank.
// Overflow checks follow CSR_CNT_OVF_EN when it is defined for the build.
module tb_csr_counter_bank;
  localparam int NUM_HPM = 2;
  localparam int W       = 40;
  localparam int NC      = NUM_HPM + 3;
  localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

  logic               clk;
  logic               nrst;
  logic [11:0]        raddr;
  logic [31:0]        rdata;
  logic               raddr_err;
  logic               wen;
  logic [11:0]        waddr;
  logic [31:0]        wdata;
  logic               retire;
  logic [NUM_HPM-1:0] hpm_event;
  logic               ovf_irq;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [63:0] m_cnt [NC];
  logic [31:0] m_inh;
  logic [31:0] m_ovf;
  logic        m_irq;

  logic [11:0] map_list [9];
  logic [11:0] rnd_list [12];

  csr_counter_bank #(.NUM_HPM(NUM_HPM), .CNT_WIDTH(W)) dut (
    .clk(clk), .nrst(nrst), .raddr(raddr), .rdata(rdata), .raddr_err(raddr_err),
    .wen(wen), .waddr(waddr), .wdata(wdata), .retire(retire),
    .hpm_event(hpm_event), .ovf_irq(ovf_irq)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic bit impl(input int k);
    return (k == 0) || (k == 2) || (k >= 3 && k < NC);
  endfunction

  function automatic void exp_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    logic [63:0] t;
    d = '0;
    e = 1'b1;
    for (int k = 0; k < NC; k++) begin
      if (impl(k) && a == 12'hC00 + 12'(k)) begin
        d = m_cnt[k][31:0];
        e = 1'b0;
      end
      if (impl(k) && a == 12'hC80 + 12'(k)) begin
        t = m_cnt[k] >> 32;
        d = t[31:0];
        e = 1'b0;
      end
    end
    if (a == 12'h320) begin
      d = m_inh;
      e = 1'b0;
    end
`ifdef CSR_CNT_OVF_EN
    if (a == 12'h7C0) begin
      d = m_ovf;
      e = 1'b0;
    end
`endif
  endfunction

  task automatic model_update(input bit rst, input bit w, input logic [11:0] wa,
                              input logic [31:0] wd, input bit ret, input logic [NUM_HPM-1:0] ev);
    logic [31:0] set;
    logic [31:0] imask;
    bit          evk;
    bit          new_irq;
    set   = '0;
    imask = '0;
    if (rst) begin
      for (int k = 0; k < NC; k++) m_cnt[k] = '0;
      m_inh = '0;
      m_ovf = '0;
      m_irq = 1'b0;
      return;
    end
    new_irq = (m_ovf != 0);
    for (int k = 0; k < NC; k++) begin
      if (!impl(k)) continue;
      imask[k] = 1'b1;
      if (k == 0)      evk = 1'b1;
      else if (k == 2) evk = ret;
      else             evk = ev[k-3];
      if (w && wa == 12'hC00 + 12'(k)) begin
        m_cnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | {32'd0, wd};
      end else if (w && wa == 12'hC80 + 12'(k)) begin
        m_cnt[k] = (m_cnt[k] & 64'hFFFF_FFFF) | (({32'd0, wd} << 32) & MASK);
      end else if (evk && !m_inh[k]) begin
        if (m_cnt[k] == MASK) begin
          m_cnt[k] = '0;
          set[k]   = 1'b1;
        end else begin
          m_cnt[k] = m_cnt[k] + 64'd1;
        end
      end
    end
    if (w && wa == 12'h320) m_inh = wd & imask;
`ifdef CSR_CNT_OVF_EN
    if (w && wa == 12'h7C0) m_ovf = m_ovf & ~wd;
    m_ovf = m_ovf | set;
    m_irq = new_irq;
`else
    m_ovf = '0;
    m_irq = 1'b0;
`endif
  endtask

  // Drives one clock cycle of stimulus and advances the model at the same edge.
  task automatic do_cycle(input bit rst, input bit w, input logic [11:0] wa,
                          input logic [31:0] wd, input bit ret, input logic [NUM_HPM-1:0] ev);
    nrst      = !rst;
    wen       = w;
    waddr     = wa;
    wdata     = wd;
    retire    = ret;
    hpm_event = ev;
    @(posedge clk);
    model_update(rst, w, wa, wd, ret, ev);
    #1;
    nrst      = 1'b1;
    wen       = 1'b0;
    wdata     = '0;
    retire    = 1'b0;
    hpm_event = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 12'h000, 32'd0, 0, '0);
  endtask

  task automatic test_reset;
    logic [31:0] e;
    logic        ee;
    do_cycle(1, 1, 12'hC02, 32'd55, 1, 2'b11);
    do_cycle(1, 1, 12'hC00, 32'd77, 1, 2'b11);
    for (int i = 0; i < 9; i++) begin
      raddr = map_list[i];
      #1;
      exp_read(raddr, e, ee);
      n_checks++;
      if (rdata !== 32'd0 || raddr_err !== 1'b0 || rdata !== e) begin
        n_fail++;
        $display("FAIL reset_read addr=%h got rdata=%h err=%b want rdata=0 err=0", raddr, rdata, raddr_err);
      end
    end
    n_checks++;
    if (ovf_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq got %b want 0", ovf_irq);
    end
  endtask

  task automatic test_idle;
    idle(10);
    raddr = 12'hC00; #1;
    n_checks++;
    if (rdata !== 32'd10) begin n_fail++; $display("FAIL idle_cycle got %0d want 10", rdata); end
    raddr = 12'hC80; #1;
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL idle_cycle_hi got %h want 0", rdata); end
    raddr = 12'hC02; #1;
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL idle_instret got %h want 0", rdata); end
  endtask

  task automatic test_carry;
    do_cycle(0, 1, 12'hC00, 32'hFFFF_FFFF, 0, '0);
    raddr = 12'hC00; #1;
    n_checks++;
    if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL carry_write_lo got %h want ffffffff", rdata); end
    raddr = 12'hC80; #1;
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL carry_write_hi got %h want 0", rdata); end
    idle(1);
    raddr = 12'hC80; #1;
    n_checks++;
    if (rdata !== 32'd1) begin n_fail++; $display("FAIL carry_inc_hi got %h want 1", rdata); end
    raddr = 12'hC00; #1;
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL carry_inc_lo got %h want 0", rdata); end
  endtask

  task automatic test_inhibit;
    logic [31:0] e;
    logic        ee;
    do_cycle(0, 1, 12'h320, 32'h5, 0, '0);
    for (int i = 0; i < 3; i++) do_cycle(0, 0, 12'h000, 32'd0, 1, 2'b01);
    raddr = 12'hC00; #1;
    exp_read(raddr, e, ee);
    n_checks++;
    if (rdata !== e) begin n_fail++; $display("FAIL inhibit_cycle got %h want %h", rdata, e); end
    raddr = 12'hC02; #1;
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL inhibit_instret got %h want 0", rdata); end
    raddr = 12'hC03; #1;
    n_checks++;
    if (rdata !== 32'd3) begin n_fail++; $display("FAIL inhibit_hpm3 got %h want 3", rdata); end
    raddr = 12'h320; #1;
    n_checks++;
    if (rdata !== 32'h5) begin n_fail++; $display("FAIL inhibit_read got %h want 5", rdata); end
    do_cycle(0, 1, 12'h320, 32'hFFFF_FFFF, 0, '0);
    #1;
    n_checks++;
    if (rdata !== 32'h1D) begin n_fail++; $display("FAIL inhibit_impl_bits got %h want 1d", rdata); end
    do_cycle(0, 1, 12'h320, 32'h0, 0, '0);
  endtask

  task automatic test_unmapped;
    logic [11:0] bad [7];
    logic [31:0] e;
    logic        ee;
    bad[0] = 12'hC05; bad[1] = 12'hC85; bad[2] = 12'hC01; bad[3] = 12'hC81;
    bad[4] = 12'h321; bad[5] = 12'h000; bad[6] = 12'hC1F;
    for (int i = 0; i < 7; i++) begin
      raddr = bad[i]; #1;
      n_checks++;
      if (rdata !== 32'd0 || raddr_err !== 1'b1) begin
        n_fail++;
        $display("FAIL unmapped_read addr=%h got rdata=%h err=%b want 0 1", raddr, rdata, raddr_err);
      end
    end
`ifndef CSR_CNT_OVF_EN
    raddr = 12'h7C0; #1;
    n_checks++;
    if (rdata !== 32'd0 || raddr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL unmapped_7c0 got rdata=%h err=%b want 0 1", rdata, raddr_err);
    end
`endif
    do_cycle(0, 1, 12'hC05, 32'h1234, 0, '0);
    do_cycle(0, 1, 12'hC85, 32'h99, 0, '0);
    do_cycle(0, 1, 12'hC01, 32'h77, 0, '0);
    for (int i = 0; i < 9; i++) begin
      raddr = map_list[i]; #1;
      exp_read(raddr, e, ee);
      n_checks++;
      if (rdata !== e || raddr_err !== ee) begin
        n_fail++;
        $display("FAIL unmapped_write_effect addr=%h got %h/%b want %h/%b", raddr, rdata, raddr_err, e, ee);
      end
    end
  endtask

  task automatic test_high_write;
    do_cycle(0, 1, 12'hC83, 32'hFFFF_FFFF, 0, '0);
    raddr = 12'hC83; #1;
    n_checks++;
    if (rdata !== 32'hFF) begin n_fail++; $display("FAIL high_write_trunc got %h want ff", rdata); end
    do_cycle(0, 1, 12'hC84, 32'h1234_5678, 0, 2'b11);
    raddr = 12'hC84; #1;
    n_checks++;
    if (rdata !== 32'h78) begin n_fail++; $display("FAIL high_write_hpm4 got %h want 78", rdata); end
  endtask

  task automatic test_same_cycle;
    logic [31:0] e;
    logic [31:0] wd;
    logic        ee;
    wd        = $urandom;
    raddr     = 12'hC04;
    wen       = 1'b1;
    waddr     = 12'hC04;
    wdata     = wd;
    hpm_event = 2'b10;
    #1;
    exp_read(raddr, e, ee);
    n_checks++;
    if (rdata !== e) begin n_fail++; $display("FAIL same_cycle_old got %h want %h", rdata, e); end
    do_cycle(0, 1, 12'hC04, wd, 0, 2'b10);
    #1;
    n_checks++;
    if (rdata !== wd) begin n_fail++; $display("FAIL same_cycle_new got %h want %h", rdata, wd); end
  endtask

  task automatic test_ovf;
    do_cycle(0, 1, 12'hC83, 32'hFF, 0, '0);
    do_cycle(0, 1, 12'hC03, 32'hFFFF_FFFF, 0, '0);
    do_cycle(0, 0, 12'h000, 32'd0, 0, 2'b01);
    raddr = 12'hC03; #1;
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL ovf_wrap_lo got %h want 0", rdata); end
    raddr = 12'hC83; #1;
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL ovf_wrap_hi got %h want 0", rdata); end
`ifdef CSR_CNT_OVF_EN
    raddr = 12'h7C0; #1;
    n_checks++;
    if (rdata !== 32'h8) begin n_fail++; $display("FAIL ovf_flag got %h want 8", rdata); end
    n_checks++;
    if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_early got %b want 0", ovf_irq); end
    idle(1);
    n_checks++;
    if (ovf_irq !== 1'b1) begin n_fail++; $display("FAIL ovf_irq_set got %b want 1", ovf_irq); end
    do_cycle(0, 1, 12'h7C0, 32'h8, 0, '0);
    raddr = 12'h7C0; #1;
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL ovf_clear got %h want 0", rdata); end
    idle(1);
    n_checks++;
    if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_clear got %b want 0", ovf_irq); end
    do_cycle(0, 1, 12'hC83, 32'hFF, 0, '0);
    do_cycle(0, 1, 12'hC03, 32'hFFFF_FFFF, 0, '0);
    do_cycle(0, 1, 12'h7C0, 32'h8, 0, 2'b01);
    raddr = 12'h7C0; #1;
    n_checks++;
    if (rdata !== 32'h8) begin n_fail++; $display("FAIL ovf_set_beats_clear got %h want 8", rdata); end
    do_cycle(0, 1, 12'hC04, 32'h0, 0, '0);
    raddr = 12'h7C0; #1;
    n_checks++;
    if (rdata !== 32'h8) begin n_fail++; $display("FAIL ovf_write_no_flag got %h want 8", rdata); end
    do_cycle(0, 1, 12'h7C0, 32'hFFFF_FFFF, 0, '0);
    idle(1);
`else
    idle(1);
    n_checks++;
    if (ovf_irq !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_tied got %b want 0", ovf_irq); end
`endif
  endtask

  task automatic test_random;
    logic [31:0] e;
    logic        ee;
    logic [11:0] wa;
    logic [31:0] wd;
    bit          w;
    bit          ret;
    logic [NUM_HPM-1:0] ev;
    for (int i = 0; i < 400; i++) begin
      w   = ($urandom_range(0, 2) == 0);
      wa  = rnd_list[$urandom_range(0, 11)];
      wd  = (wa == 12'h320) ? 32'($urandom_range(0, 31)) : $urandom;
      ret = $urandom_range(0, 1);
      ev  = NUM_HPM'($urandom_range(0, 3));
      raddr = rnd_list[$urandom_range(0, 11)];
      #1;
      exp_read(raddr, e, ee);
      n_checks++;
      if (rdata !== e || raddr_err !== ee || ovf_irq !== m_irq) begin
        n_fail++;
        $display("FAIL random_read i=%0d addr=%h got %h/%b/%b want %h/%b/%b",
                 i, raddr, rdata, raddr_err, ovf_irq, e, ee, m_irq);
      end
      do_cycle(0, w, wa, wd, ret, ev);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 12'h000, 32'd0, 1, 2'b11);
    do_cycle(1, 1, 12'hC02, 32'hABCD, 1, 2'b11);
    for (int i = 0; i < 9; i++) begin
      raddr = map_list[i]; #1;
      n_checks++;
      if (rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_mid_read addr=%h got %h want 0", raddr, rdata);
      end
    end
    idle(1);
    raddr = 12'hC00; #1;
    n_checks++;
    if (rdata !== 32'd1) begin n_fail++; $display("FAIL reset_resume_cycle got %h want 1", rdata); end
    raddr = 12'hC02; #1;
    n_checks++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_lost_write got %h want 0", rdata); end
  endtask

  initial begin
    for (int k = 0; k < NC; k++) m_cnt[k] = '0;
    m_inh = '0;
    m_ovf = '0;
    m_irq = 1'b0;
    map_list[0] = 12'hC00; map_list[1] = 12'hC80; map_list[2] = 12'hC02;
    map_list[3] = 12'hC82; map_list[4] = 12'hC03; map_list[5] = 12'hC83;
    map_list[6] = 12'hC04; map_list[7] = 12'hC84; map_list[8] = 12'h320;
    for (int i = 0; i < 9; i++) rnd_list[i] = map_list[i];
    rnd_list[9] = 12'h7C0; rnd_list[10] = 12'hC05; rnd_list[11] = 12'hC01;
    nrst      = 1'b0;
    raddr     = '0;
    wen       = 1'b0;
    waddr     = '0;
    wdata     = '0;
    retire    = 1'b0;
    hpm_event = '0;
    #1;
    test_reset;
    test_idle;
    test_carry;
    test_inhibit;
    test_unmapped;
    test_high_write;
    test_same_cycle;
    test_ovf;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_counter_bank.md
CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

Interface
REQ-001 Parameter NUM_HPM, default 4: number of hardware performance counters hpmcounter3..(3+NUM_HPM-1); legal range 1..29.
REQ-002 Parameter CNT_WIDTH, default 64: width of every counter; legal range 33..64.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 raddr  input  12  CSR read address.
REQ-006 rdata  output  32  read data, combinational from current register state.
REQ-007 raddr_err  output  1  high when raddr is unmapped.
REQ-008 wen  input  1  CSR write strobe.
REQ-009 waddr  input  12  CSR write address.
REQ-010 wdata  input  32  CSR write data.
REQ-011 retire  input  1  one instruction retired in writeback this cycle.
REQ-012 hpm_event  input  NUM_HPM  per-counter event pulses; bit i advances hpmcounter(3+i).
REQ-013 ovf_irq  output  1  counter-overflow interrupt request.

Function
REQ-014 Map: cycle 0xC00/0xC80, instret 0xC02/0xC82, hpmcounter(3+i) 0xC03+i / 0xC83+i (low/high word), mcountinhibit 0x320; every other address is unmapped.
REQ-015 The low-word read returns counter[31:0]; the high-word read returns counter[CNT_WIDTH-1:32], zero-extended to 32 bits.
REQ-016 A read of mcountinhibit returns bit0 = cycle, bit1 = 0 (time, reserved), bit2 = instret, bit(3+i) = hpm i, with upper bits 0.
REQ-017 An unmapped read returns rdata = 0 and raddr_err = 1; raddr_err = 0 otherwise.
REQ-018 Each cycle, cycle increments by 1 unless inhibited; instret increments by 1 when retire = 1; hpm i increments by 1 when hpm_event[i] = 1.
REQ-019 A set mcountinhibit bit freezes its counter; the freeze takes effect in the cycle after the inhibit write.
REQ-020 All counters wrap modulo 2^CNT_WIDTH.
REQ-021 A low-word write sets counter = {counter[CNT_WIDTH-1:32], wdata}, with no carry into the high word.
REQ-022 A high-word write sets counter[CNT_WIDTH-1:32] = wdata[CNT_WIDTH-33:0]; excess wdata bits are dropped.
REQ-023 The counter being written does not increment in the write cycle; all other counters keep counting normally, so a write does not stall the bank.
REQ-024 A write to mcountinhibit loads the implemented bits; bit1 and unimplemented bits stay 0.
REQ-025 Writes to unmapped addresses are ignored with no side effects.
REQ-026 When raddr == waddr in the same cycle, rdata returns the pre-write value; the new value is visible in the next cycle.

Reset
REQ-027 While nrst = 0 at a rising edge, all counters, mcountinhibit and the overflow flags clear to 0; this takes priority over any write or increment in that cycle.
REQ-028 During and after reset: rdata follows the cleared state (0), and ovf_irq = 0.
REQ-029 Reset asserted mid-count discards the in-flight increment; counting resumes from 0 in the first cycle with nrst = 1.

Configuration
REQ-030 Macro CSR_CNT_OVF_EN compiles in overflow detection; without the macro, ovf_irq is tied to 0 and address 0x7C0 is unmapped.
REQ-031 With CSR_CNT_OVF_EN: a sticky flag per counter (same bit layout as mcountinhibit) sets when an increment wraps the counter from all-ones to 0; wraps caused by writes never set a flag.
REQ-032 With CSR_CNT_OVF_EN: 0x7C0 reads the flag vector; a write to 0x7C0 is write-1-to-clear.
REQ-033 With CSR_CNT_OVF_EN: a set event in the same cycle as a clear of the same bit leaves the flag set.
REQ-034 With CSR_CNT_OVF_EN: ovf_irq is registered, equal to the OR of all flags, and appears one cycle after a flag sets.

Verification
REQ-035 Reset then 10 idle cycles, inhibit = 0 -> read 0xC00 = 10, 0xC80 = 0, 0xC02 = 0.
REQ-036 Write 0xC00 = 0xFFFFFFFF, then run 1 cycle -> 0xC80 = 1 and 0xC00 = 0 (carry on increment, none on write).
REQ-037 Write 0x320 = 0x5, pulse retire and hpm_event[0] for 3 cycles -> cycle and instret frozen, 0xC03 = 3.
REQ-038 NUM_HPM = 2: read 0xC05 -> rdata = 0, raddr_err = 1; write 0xC05 -> no state change.
REQ-039 CSR_CNT_OVF_EN, CNT_WIDTH = 40: preload hpm3 to 2^40-1, pulse the event -> hpm3 = 0, 0x7C0 bit3 = 1, ovf_irq = 1 next cycle; write 0x7C0 = 0x8 -> ovf_irq = 0.
REQ-040 Assert nrst = 0 for 1 cycle during counting with wen = 1 -> all reads 0 and the write is lost.
